// File: rtl/prod_accum_if.sv
// Handshake bundle between a product source / result sink and prod_accum.
// The master side is the environment; the slave side is the accumulator.
interface prod_accum_if #(
    parameter int ACC_W = 20,
    parameter int LEN_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      product;
    logic [LEN_W-1:0] len;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic [LEN_W:0]   out_count;
    logic             overflow;

    modport master (
        output in_valid, product, len, out_ready,
        input  in_ready, out_valid, acc_out, out_count, overflow
    );

    modport slave (
        input  in_valid, product, len, out_ready,
        output in_ready, out_valid, acc_out, out_count, overflow
    );
endinterface

// File: rtl/prod_accum.sv
// Frame accumulator: sums len unsigned 16-bit products, then holds the
// sum, the product count and a sticky carry-out flag until the sink takes them.
module prod_accum #(
    parameter int ACC_W = 20,
    parameter int LEN_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    prod_accum_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic [LEN_W:0]   len_q, len_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic             in_ready_s;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic [LEN_W:0]   len_ext_s;
    logic [LEN_W:0]   cnt_inc_s;
    logic [ACC_W:0]   sum_s;

    function automatic logic [ACC_W:0] add_zext(input logic [ACC_W-1:0] a,
                                                input logic [15:0]      p);
        return {1'b0, a} + {{(ACC_W-15){1'b0}}, p};
    endfunction

    // A length of zero encodes a full 2^LEN_W frame.
    assign len_ext_s  = (bus.len == {LEN_W{1'b0}}) ? {1'b1, {LEN_W{1'b0}}}
                                                   : {1'b0, bus.len};
    assign cnt_inc_s  = cnt_q + {{LEN_W{1'b0}}, 1'b1};
    assign sum_s      = add_zext(acc_q, bus.product);

    // Reset is folded in so no product can be taken while rst is low.
    assign in_ready_s = rst & ~clear & (state_q != HOLD);
    assign in_xfer_s  = bus.in_valid & in_ready_s;
    assign out_xfer_s = out_valid_q & bus.out_ready;

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_q;
    assign bus.out_count = cnt_q;
    assign bus.overflow  = ovf_q;

    // Next-state and datapath update for the frame FSM.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        if (clear) begin
            state_d     = IDLE;
            acc_d       = {ACC_W{1'b0}};
            cnt_d       = {(LEN_W+1){1'b0}};
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_xfer_s) begin
                        len_d = len_ext_s;
                        acc_d = {{(ACC_W-16){1'b0}}, bus.product};
                        cnt_d = {{LEN_W{1'b0}}, 1'b1};
                        ovf_d = 1'b0;
                        if (len_ext_s == {{LEN_W{1'b0}}, 1'b1}) begin
                            state_d     = HOLD;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d     = ACCUM;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                ACCUM: begin
                    if (in_xfer_s) begin
                        acc_d = sum_s[ACC_W-1:0];
                        ovf_d = ovf_q | sum_s[ACC_W];
                        cnt_d = cnt_inc_s;
                        if (cnt_inc_s == len_q) begin
                            state_d     = HOLD;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d     = ACCUM;
                        end
                    end else begin
                        state_d = ACCUM;
                    end
                end
                HOLD: begin
                    if (out_xfer_s) begin
                        state_d     = IDLE;
                        acc_d       = {ACC_W{1'b0}};
                        cnt_d       = {(LEN_W+1){1'b0}};
                        ovf_d       = 1'b0;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    acc_d       = {ACC_W{1'b0}};
                    cnt_d       = {(LEN_W+1){1'b0}};
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {(LEN_W+1){1'b0}};
            len_q       <= {(LEN_W+1){1'b0}};
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: expected frame results go into a queue,
// a negedge monitor pops and compares them at every output transfer.
module tb_prod_accum;
    localparam int ACC_W = 20;
    localparam int LEN_W = 8;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic [LEN_W:0]   cnt;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst;
    logic clear;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    prod_accum_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

    prod_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [ACC_W-1:0] a, input logic [LEN_W:0] c, input logic o);
        exp_t e;
        e.acc = a;
        e.cnt = c;
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    // Monitor: one pop per output transfer.
    always @(negedge clk) begin
        if (rst && !clear && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("acc_out", 32'(bus.acc_out), 32'(e.acc));
                chk("out_count", 32'(bus.out_count), 32'(e.cnt));
                chk("overflow", 32'(bus.overflow), 32'(e.ovf));
            end
        end
    end

    task automatic send(input logic [15:0] p, input logic [LEN_W-1:0] l);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.product  = p;
        bus.len      = l;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit found;
        found = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("drain_found", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.product   = 16'h0000;
        bus.len       = 8'd0;
        bus.out_ready = 1'b0;

        // Reset state.
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_acc_out", 32'(bus.acc_out), 32'd0);
        chk("rst_out_count", 32'(bus.out_count), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        idle(2);
        rst = 1'b1;

        // Basic frame with latency check.
        push_exp(20'h3FFFC, 9'd4, 1'b0);
        for (int i = 0; i < 3; i++) send(16'hFFFF, 8'd4);
        chk("lat_not_early", 32'(bus.out_valid), 32'd0);
        send(16'hFFFF, 8'd4);
        chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        drain();
        @(negedge clk);
        chk("next_frame_ready", 32'(bus.in_ready), 32'd1);
        idle(1);

        // Overflow frame then a single-product frame.
        push_exp(20'h0FFEF, 9'd17, 1'b1);
        for (int i = 0; i < 17; i++) send(16'hFFFF, 8'd17);
        drain();
        push_exp(20'h00001, 9'd1, 1'b0);
        send(16'h0001, 8'd1);
        chk("len1_out_valid", 32'(bus.out_valid), 32'd1);
        drain();

        // Gaps and back-pressure; product in HOLD not consumed.
        push_exp(20'd6, 9'd3, 1'b0);
        send(16'd1, 8'd3);
        idle(2);
        send(16'd2, 8'd3);
        idle(2);
        send(16'd3, 8'd3);
        bus.in_valid = 1'b1;
        bus.product  = 16'h00AA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_acc_hold", 32'(bus.acc_out), 32'd6);
            chk("bp_cnt_hold", 32'(bus.out_count), 32'd3);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready_after", 32'(bus.in_ready), 32'd1);
        chk("bp_valid_after", 32'(bus.out_valid), 32'd0);
        idle(1);

        // Clear mid-frame.
        send(16'd10, 8'd4);
        send(16'd20, 8'd4);
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.product  = 16'd99;
        @(negedge clk);
        chk("clr_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
        chk("clr_acc", 32'(bus.acc_out), 32'd0);
        chk("clr_cnt", 32'(bus.out_count), 32'd0);
        push_exp(20'd8, 9'd2, 1'b0);
        send(16'd3, 8'd2);
        send(16'd5, 8'd2);
        drain();

        // Reset mid-frame, then a full 256-product frame.
        for (int i = 0; i < 3; i++) send(16'd5, 8'd8);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_acc", 32'(bus.acc_out), 32'd0);
        chk("arst_cnt", 32'(bus.out_count), 32'd0);
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_ready", 32'(bus.in_ready), 32'd0);
        idle(2);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.product  = 16'h0100;
        bus.len      = 8'd0;
        @(negedge clk);
        chk("first_after_rst", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        push_exp(20'h10000, 9'd256, 1'b0);
        for (int i = 1; i < 256; i++) send(16'h0100, 8'd5);
        chk("full_frame_valid", 32'(bus.out_valid), 32'd1);
        drain();

        idle(2);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter ACC_W, default 20, SHALL set the accumulator width in bits; legal range is 17 to 32.
REQ-002 Parameter LEN_W, default 8, SHALL set the frame-length field width in bits.
REQ-003 clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 clear, input, 1 bit: synchronous frame abort.
REQ-006 in_valid, input, 1 bit: a product is presented this cycle.
REQ-007 in_ready, output, 1 bit: the block can accept a product this cycle.
REQ-008 product, input, 16 bits: unsigned 8x8 multiplier result.
REQ-009 len, input, LEN_W bits: products per frame, sampled on the first accepted product; 0 means 2^LEN_W.
REQ-010 out_valid, output, 1 bit: the frame result is available.
REQ-011 out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 acc_out, output, ACC_W bits: the frame sum modulo 2^ACC_W.
REQ-013 out_count, output, LEN_W+1 bits: the number of products accumulated in the frame.
REQ-014 overflow, output, 1 bit: sticky; set if any addition in the frame carried out of ACC_W.

Function
REQ-015 An input transfer SHALL occur only in a cycle where in_valid=1, in_ready=1 and clear=0.
REQ-016 An output transfer SHALL occur only in a cycle where out_valid=1 and out_ready=1.
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCUM and HOLD.
REQ-018 IDLE: in_ready=1 and out_valid=0.
- On an input transfer: len latched as len_q (0 maps to 2^LEN_W), acc=product zero-extended, cnt=1.
- Next state: HOLD if len_q=1, otherwise ACCUM.
REQ-019 ACCUM: in_ready=1 and out_valid=0.
- On each input transfer: acc=acc+product zero-extended (mod 2^ACC_W), cnt=cnt+1, overflow set on carry-out.
- When the updated cnt equals len_q, next state SHALL be HOLD.
REQ-020 Cycles with in_valid=0 SHALL leave acc, cnt, overflow and the state unchanged.
REQ-021 HOLD: out_valid=1, in_ready=0.
- acc_out, out_count and overflow SHALL stay stable until the output transfer.
- On the output transfer: next state IDLE, acc=0, cnt=0, overflow=0.
REQ-022 out_valid SHALL rise in the cycle after the last product of the frame is accepted (latency 1).
REQ-023 Throughput SHALL be one product per cycle inside a frame.
REQ-024 The first product of the next frame SHALL be acceptable in the cycle after the output transfer.
REQ-025 Products presented while in HOLD SHALL be ignored and SHALL NOT be consumed.
REQ-026 acc_out SHALL be driven from registered state only, with no combinational path from product.
REQ-027 clear=1 in any state: in_ready=0 that cycle and the presented product is not consumed.
- Next state IDLE; acc, cnt, overflow and out_valid cleared.
- This applies even in HOLD with out_ready=1; the result is discarded.
REQ-028 out_count SHALL equal cnt, which is len_q when in HOLD.
REQ-029 A change of the len input after the first transfer of a frame SHALL NOT affect the current frame.

Reset
REQ-030 While rst=0, and immediately and asynchronously on its assertion:
- state=IDLE; acc, cnt, len_q and overflow = 0.
- out_valid=0, acc_out=0, out_count=0.
- in_ready SHALL be 0 while rst=0.
REQ-031 Reset asserted mid-frame or in HOLD SHALL discard all partial results.
- The first transfer SHALL be possible on the first rising clk edge after rst returns to 1.

Verification
REQ-032 Basic frame: len=4; products 0xFFFF x4 back-to-back.
- Response: out_valid one cycle after the 4th product; acc_out=0x3FFFC, out_count=4, overflow=0.
REQ-033 Overflow: len=17; 17 products of 0xFFFF.
- Response: acc_out=0x0FFEF, overflow=1.
- After the output transfer, a frame of len=1 with product 0x0001 gives acc_out=0x00001, overflow=0.
REQ-034 Back-pressure and gaps: len=3; products 1, 2, 3 with 2 idle cycles between each; out_ready=0 for 5 cycles.
- Response: acc_out=6 and out_count=3 held; in_ready=0; product 0x00AA driven in HOLD not consumed.
- in_ready=1 in the cycle after out_ready rises.
REQ-035 Clear mid-frame: len=4; products 10 and 20 accepted, then clear=1 with in_valid=1 and product 99.
- Response: IDLE, no out_valid.
- Then len=2 with products 3 and 5 gives acc_out=8, out_count=2.
REQ-036 Reset mid-frame: len=8; rst=0 after 3 products.
- Response: all outputs 0 without waiting for a clock edge.
- After release, len=0 with 256 products of 0x0100 gives acc_out=0x10000, out_count=256, overflow=0.
